// File: rtl/led_anim_engine.sv
// ---------------------------------------------------------------------------
// led_anim_engine
//   Parametrised LED animation engine. A prescaler derived from BASE_PERIOD
//   and the speed select produces frame steps. On each step the pattern
//   generator advances the LED frame for the selected mode
//   (RUN / BOUNCE / FILL / BLINK).
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous reset, active-high
//   speed       in   SPEED_W  frame period P = max(BASE_PERIOD >> speed, 1)
//   mode        in   2        0 RUN, 1 BOUNCE, 2 FILL, 3 BLINK
//   dir         in   1        RUN only: 0 = toward MSB, 1 = toward LSB
//   pause       in   1        1 = freeze animation
//   led         out  LED_W    current frame, registered
//   frame_tick  out  1        1-cycle pulse when a stepped frame appears on led
// ---------------------------------------------------------------------------
module led_anim_engine #(
    parameter int unsigned LED_W       = 16,
    parameter int unsigned BASE_PERIOD = 25_000_000,
    parameter int unsigned SPEED_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic               pause,
    output logic [LED_W-1:0]   led,
    output logic               frame_tick
);

    localparam int unsigned CNT_W = $clog2(BASE_PERIOD + 1);

    localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);

    // Alternating pattern with bit0 set: ...0101
    localparam logic [2*LED_W-1:0] ALT_WIDE = {LED_W{2'b01}};
    localparam logic [LED_W-1:0]   ALT_PAT  = ALT_WIDE[LED_W-1:0];

    localparam logic [LED_W-1:0] ONE_HOT0 = LED_W'(1);

    typedef enum logic [1:0] {
        M_RUN    = 2'd0,
        M_BOUNCE = 2'd1,
        M_FILL   = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        B_UP   = 1'b0,
        B_DOWN = 1'b1
    } bdir_t;

    mode_t              mode_q, mode_d;
    mode_t              mode_sel;
    bdir_t              bdir_q, bdir_d, bdir_step;
    logic [LED_W-1:0]   led_q, led_d, led_step, led_start;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   shifted, limit;
    logic               tick_q, tick_d;
    logic               fill_bit;

    assign mode_sel = mode_t'(mode);

    // Terminal count P-1, with P clamped to at least 1
    always_comb begin
        shifted = BASE_P >> speed;
        limit   = (shifted == '0) ? '0 : shifted - CNT_W'(1);
    end

    // Start frame for the requested mode
    always_comb begin
        unique case (mode_sel)
            M_RUN:    led_start = ONE_HOT0;
            M_BOUNCE: led_start = ONE_HOT0;
            M_FILL:   led_start = '0;
            M_BLINK:  led_start = ALT_PAT;
            default:  led_start = ONE_HOT0;
        endcase
    end

    // Next frame if a step happens this cycle
    always_comb begin
        led_step  = led_q;
        bdir_step = bdir_q;
        fill_bit  = 1'b0;
        unique case (mode_q)
            M_RUN: begin
                if (dir)
                    led_step = {led_q[0], led_q[LED_W-1:1]};
                else
                    led_step = {led_q[LED_W-2:0], led_q[LED_W-1]};
            end
            M_BOUNCE: begin
                // Flip at an endpoint and move away in the same step, so each
                // endpoint is shown only once per pass.
                if (bdir_q == B_UP) begin
                    if (led_q[LED_W-1]) begin
                        bdir_step = B_DOWN;
                        led_step  = led_q >> 1;
                    end else begin
                        led_step  = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        bdir_step = B_UP;
                        led_step  = led_q << 1;
                    end else begin
                        led_step  = led_q >> 1;
                    end
                end
            end
            M_FILL: begin
                if (led_q == '0)
                    fill_bit = 1'b1;
                else if (led_q == '1)
                    fill_bit = 1'b0;
                else
                    fill_bit = led_q[0];
                led_step = {led_q[LED_W-2:0], fill_bit};
            end
            M_BLINK: begin
                led_step = ~led_q;
            end
            default: led_step = led_q;
        endcase
    end

    // Next-state: a mode change wins over a step and also applies while paused
    always_comb begin
        mode_d = mode_q;
        bdir_d = bdir_q;
        led_d  = led_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (mode_sel != mode_q) begin
            mode_d = mode_sel;
            led_d  = led_start;
            cnt_d  = '0;
            bdir_d = B_UP;
        end else if (!pause) begin
            if (cnt_q >= limit) begin
                cnt_d  = '0;
                led_d  = led_step;
                bdir_d = bdir_step;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_RUN;
            bdir_q <= B_UP;
            led_q  <= ONE_HOT0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            bdir_q <= bdir_d;
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign led        = led_q;
    assign frame_tick = tick_q;

endmodule
